// File: rtl/rot_enc_pkg.sv
// Shared types and helpers for the rotary encoder front-panel controller.
package rot_enc_pkg;

  typedef enum logic {
    DIR_CW  = 1'b0,
    DIR_CCW = 1'b1
  } dir_e;

  localparam int QACC_FULL = 4;

  typedef struct packed {
    logic signed [1:0] delta;
    logic              illegal;
  } qstep_t;

  // Position of an A/B state along the CW Gray sequence 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  function automatic qstep_t qstep(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] diff;
    qstep_t     r;
    diff      = gray_idx(cur_ab) - gray_idx(prev_ab);
    r.delta   = 2'b00;
    r.illegal = 1'b0;
    unique case (diff)
      2'd1:    r.delta = 2'b01;
      2'd3:    r.delta = 2'b11;
      2'd2:    r.illegal = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rot_enc_ctrl_key_debounce.sv
// Two-flop synchroniser plus stability-counter debounce for the push key.
module key_debounce #(
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned    CntW    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

  logic            meta_q, meta_d;
  logic            sync_q, sync_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d  = d_i;
    sync_d  = meta_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = cnt_q;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d   = '0;
      level_d = ~level_q;
      rise_d  = ~level_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/rot_enc_ctrl.sv
// Quadrature decode, saturating position counter and key press/long-press events.
module rot_enc_ctrl
  import rot_enc_pkg::*;
#(
  parameter int unsigned POS_W       = 16,
  parameter int          POS_MIN     = -32768,
  parameter int          POS_MAX     = 32767,
  parameter int unsigned DB_CYCLES   = 50000,
  parameter int unsigned LONG_CYCLES = 50000000,
  parameter bit          CLR_ON_LONG = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enc_a_i,
  input  logic                    enc_b_i,
  input  logic                    key_i,
  input  logic                    err_clr_i,
  output logic                    step_o,
  output logic                    dir_o,
  output logic signed [POS_W-1:0] pos_o,
  output logic                    key_level_o,
  output logic                    key_press_o,
  output logic                    key_long_o,
  output logic                    err_o
);

  localparam logic signed [POS_W-1:0] PosMax   = POS_W'(POS_MAX);
  localparam logic signed [POS_W-1:0] PosMin   = POS_W'(POS_MIN);
  localparam logic signed [3:0]       QaccPos  = 4'(QACC_FULL);
  localparam logic signed [3:0]       QaccNeg  = 4'(-QACC_FULL);
  // Hold counter parks one past the threshold so the long event fires once per press.
  localparam int unsigned             HoldW    = $clog2(LONG_CYCLES + 1);
  localparam logic [HoldW-1:0]        HoldLong = HoldW'(LONG_CYCLES - 1);
  localparam logic [HoldW-1:0]        HoldPark = HoldW'(LONG_CYCLES);

  logic [1:0]              ab_meta_q, ab_meta_d;
  logic [1:0]              ab_sync_q, ab_sync_d;
  logic [1:0]              vld_q, vld_d;
  logic [1:0]              prev_ab_q, prev_ab_d;
  logic                    prev_valid_q, prev_valid_d;
  logic signed [3:0]       qacc_q, qacc_d;
  logic                    step_q, step_d;
  dir_e                    dir_q, dir_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic                    err_q, err_d;
  logic [HoldW-1:0]        hold_q, hold_d;
  logic signed [3:0]       qacc_sum;
  qstep_t                  qs;
  logic                    key_level, key_rise, key_long;

  key_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_key_debounce (
    .clk    (clk),
    .rst    (rst),
    .d_i    (key_i),
    .level_o(key_level),
    .rise_o (key_rise)
  );

  assign key_long = key_level && (hold_q == HoldLong);

  always_comb begin
    ab_meta_d    = {enc_a_i, enc_b_i};
    ab_sync_d    = ab_meta_q;
    vld_d        = {vld_q[0], 1'b1};
    prev_ab_d    = prev_ab_q;
    prev_valid_d = prev_valid_q;
    qacc_d       = qacc_q;
    step_d       = 1'b0;
    dir_d        = dir_q;
    err_d        = err_clr_i ? 1'b0 : err_q;
    qs           = qstep(prev_ab_q, ab_sync_q);
    qacc_sum     = qacc_q + {{2{qs.delta[1]}}, qs.delta};

    // vld_q[1] marks the first sample that came through the synchroniser after reset.
    if (vld_q[1]) begin
      prev_ab_d    = ab_sync_q;
      prev_valid_d = 1'b1;
      if (prev_valid_q) begin
        if (qs.illegal) begin
          err_d  = 1'b1;
          qacc_d = '0;
        end else if (ab_sync_q != prev_ab_q) begin
          qacc_d = qacc_sum;
          if (ab_sync_q == 2'b00) begin
            qacc_d = '0;
            if (qacc_sum == QaccPos) begin
              step_d = 1'b1;
              dir_d  = DIR_CW;
            end else if (qacc_sum == QaccNeg) begin
              step_d = 1'b1;
              dir_d  = DIR_CCW;
            end
          end
        end
      end
    end

    pos_d = pos_q;
    if (CLR_ON_LONG && key_long) begin
      pos_d = '0;
    end else if (step_d) begin
      if (dir_d == DIR_CW) begin
        if (pos_q != PosMax) pos_d = pos_q + 1'b1;
      end else begin
        if (pos_q != PosMin) pos_d = pos_q - 1'b1;
      end
    end

    hold_d = hold_q;
    if (!key_level) begin
      hold_d = '0;
    end else if (hold_q != HoldPark) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ab_meta_q    <= 2'b00;
      ab_sync_q    <= 2'b00;
      vld_q        <= 2'b00;
      prev_ab_q    <= 2'b00;
      prev_valid_q <= 1'b0;
      qacc_q       <= '0;
      step_q       <= 1'b0;
      dir_q        <= DIR_CW;
      pos_q        <= '0;
      err_q        <= 1'b0;
      hold_q       <= '0;
    end else begin
      ab_meta_q    <= ab_meta_d;
      ab_sync_q    <= ab_sync_d;
      vld_q        <= vld_d;
      prev_ab_q    <= prev_ab_d;
      prev_valid_q <= prev_valid_d;
      qacc_q       <= qacc_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      pos_q        <= pos_d;
      err_q        <= err_d;
      hold_q       <= hold_d;
    end
  end

  assign step_o      = step_q;
  assign dir_o       = dir_q;
  assign pos_o       = pos_q;
  assign key_level_o = key_level;
  assign key_press_o = key_rise;
  assign key_long_o  = key_long;
  assign err_o       = err_q;

endmodule

// File: tb/tb_rot_enc_ctrl.sv
// Self-checking bench for rot_enc_ctrl: behavioural model compared every cycle plus directed checks.
module tb_rot_enc_ctrl;

  localparam int DB   = 8;
  localparam int LONG = 64;
  localparam int PMIN = -4;
  localparam int PMAX = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_a_i = 1'b0, enc_b_i = 1'b0, key_i = 1'b0, err_clr_i = 1'b0;
  logic       step_o, dir_o, key_level_o, key_press_o, key_long_o, err_o;
  logic [7:0] pos_o;

  rot_enc_ctrl #(
    .POS_W(8), .POS_MIN(PMIN), .POS_MAX(PMAX),
    .DB_CYCLES(DB), .LONG_CYCLES(LONG), .CLR_ON_LONG(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .enc_a_i(enc_a_i), .enc_b_i(enc_b_i), .key_i(key_i),
    .err_clr_i(err_clr_i), .step_o(step_o), .dir_o(dir_o), .pos_o(pos_o),
    .key_level_o(key_level_o), .key_press_o(key_press_o), .key_long_o(key_long_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: expected output values after each clock edge.
  logic [2:0] hist[$];
  bit m_prev_valid = 0, m_step = 0, m_dir = 0, m_level = 0, m_press = 0, m_err = 0, m_long = 0;
  logic [1:0] m_prev = 2'b00;
  int m_turns = 0, m_pos = 0, m_run = 0, m_high = 0;

  function automatic int ring_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [2:0] smp;
    logic [1:0] cur;
    bit sv, long_now, old_level;
    int d;
    long_now = m_level && (m_high == LONG - 1);
    if (rst) begin
      hist.delete();
      m_prev_valid = 0; m_prev = 2'b00; m_turns = 0; m_step = 0; m_dir = 0;
      m_pos = 0; m_level = 0; m_press = 0; m_run = 0; m_high = 0; m_err = 0;
    end else begin
      sv  = hist.size() >= 2;
      smp = sv ? hist[hist.size()-2] : 3'b000;
      cur = smp[2:1];
      m_step = 0;
      if (err_clr_i) m_err = 0;
      if (sv) begin
        if (!m_prev_valid) begin
          m_prev_valid = 1;
        end else if (cur != m_prev) begin
          d = (ring_pos(cur) - ring_pos(m_prev) + 4) % 4;
          if (d == 2) begin
            m_err = 1;
            m_turns = 0;
          end else begin
            m_turns += (d == 1) ? 1 : -1;
            if (cur == 2'b00) begin
              if (m_turns == 4) begin m_step = 1; m_dir = 0; end
              else if (m_turns == -4) begin m_step = 1; m_dir = 1; end
              m_turns = 0;
            end
          end
        end
        m_prev = cur;
      end
      if (long_now) m_pos = 0;
      else if (m_step) m_pos = m_dir ? ((m_pos > PMIN) ? m_pos - 1 : PMIN)
                                     : ((m_pos < PMAX) ? m_pos + 1 : PMAX);
      old_level = m_level;
      m_press = 0;
      if (smp[0] == m_level) m_run = 0;
      else begin
        m_run++;
        if (m_run == DB) begin
          m_level = !m_level;
          m_run = 0;
          m_press = m_level;
        end
      end
      m_high = (old_level && m_level) ? m_high + 1 : 0;
      hist.push_back({enc_a_i, enc_b_i, key_i});
      if (hist.size() > 2) void'(hist.pop_front());
    end
    m_long = m_level && (m_high == LONG - 1);
  end

  // Per-cycle compare and event counters.
  int cyc = 0, step_tot = 0, press_tot = 0, long_tot = 0, press_cyc = 0, long_cyc = 0;
  always @(negedge clk) begin
    cyc++;
    check("step_o", step_o, m_step);
    check("dir_o", dir_o, m_dir);
    check("pos_o", $signed(pos_o), m_pos);
    check("key_level_o", key_level_o, m_level);
    check("key_press_o", key_press_o, m_press);
    check("key_long_o", key_long_o, m_long);
    check("err_o", err_o, m_err);
    if (step_o) step_tot++;
    if (key_press_o) begin press_tot++; press_cyc = cyc; end
    if (key_long_o) begin long_tot++; long_cyc = cyc; end
  end

  task automatic set_ab(input logic a, input logic b);
    enc_a_i = a;
    enc_b_i = b;
    repeat (5) @(negedge clk);
  endtask

  task automatic cw_cycle();
    set_ab(1, 0); set_ab(1, 1); set_ab(0, 1); set_ab(0, 0);
  endtask

  task automatic ccw_cycle();
    set_ab(0, 1); set_ab(1, 1); set_ab(1, 0); set_ab(0, 0);
  endtask

  int s0, p0, l0;

  initial begin
    repeat (3) @(negedge clk);
    check("reset pos", $signed(pos_o), 0);
    check("reset step", step_o, 0);
    check("reset err", err_o, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // One CW detent, with latency pinned on the final B fall.
    s0 = step_tot;
    set_ab(1, 0); set_ab(1, 1); set_ab(0, 1);
    enc_a_i = 1'b0; enc_b_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("cw step before 3rd edge", step_o, 0);
    @(posedge clk);
    #1 check("cw step at 3rd edge", step_o, 1);
    check("cw dir", dir_o, 0);
    check("cw pos", $signed(pos_o), 1);
    @(negedge clk);
    repeat (6) @(negedge clk);
    check("cw step count", step_tot - s0, 1);

    // Bouncy key then held: one press, one long press clearing pos.
    p0 = press_tot; l0 = long_tot;
    for (int i = 0; i < 30; i++) begin
      key_i = 1'b0; #20;
      key_i = 1'b1; #30;
    end
    repeat (100) @(negedge clk);
    check("press count", press_tot - p0, 1);
    check("long count", long_tot - l0, 1);
    check("long delay after press", long_cyc - press_cyc, LONG - 1);
    check("long clears pos", $signed(pos_o), 0);
    key_i = 1'b0;
    repeat (20) @(negedge clk);
    check("key released", key_level_o, 0);

    // Three CCW then two more into saturation.
    s0 = step_tot;
    repeat (3) ccw_cycle();
    repeat (4) @(negedge clk);
    check("ccw3 steps", step_tot - s0, 3);
    check("ccw3 dir", dir_o, 1);
    check("ccw3 pos", $signed(pos_o), -3);
    s0 = step_tot;
    repeat (2) ccw_cycle();
    repeat (4) @(negedge clk);
    check("sat steps", step_tot - s0, 2);
    check("sat pos", $signed(pos_o), -4);

    // Partial rotation that reverses.
    s0 = step_tot;
    set_ab(1, 0); set_ab(0, 0);
    repeat (4) @(negedge clk);
    check("partial steps", step_tot - s0, 0);
    check("partial pos", $signed(pos_o), -4);
    check("partial err", err_o, 0);

    // Illegal double transition, clear, then clear colliding with a new error.
    s0 = step_tot;
    set_ab(1, 1);
    check("illegal err", err_o, 1);
    check("illegal steps", step_tot - s0, 0);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    repeat (2) @(negedge clk);
    check("err cleared", err_o, 0);
    enc_a_i = 1'b0; enc_b_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    repeat (2) @(negedge clk);
    check("set beats clear", err_o, 1);
    repeat (3) @(negedge clk);

    // Reset mid-rotation resting at 11.
    s0 = step_tot;
    set_ab(1, 0); set_ab(1, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst pos", $signed(pos_o), 0);
    check("midrst err", err_o, 0);
    check("midrst dir", dir_o, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("reprime err", err_o, 0);
    set_ab(0, 1); set_ab(0, 0);
    repeat (4) @(negedge clk);
    check("lost detent steps", step_tot - s0, 0);
    check("lost detent err", err_o, 0);
    check("lost detent pos", $signed(pos_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rot_enc_ctrl.md
Name: rot_enc_ctrl

Overview:
Front-panel input controller for a quadrature rotary encoder (A/B phases) with an integrated push key.
- Synchronises the raw pins and decodes full detent cycles into direction-tagged step pulses.
- Maintains a saturating signed position counter.
- Debounces the key and emits press and long-press events.
- Sits between the board pins and the register/CPU-side logic; the bench drives it with the existing clock, reset, key-bounce and quadrature stimulus tasks.

Parameters:
POS_W, 16, width of signed position counter
POS_MIN, -32768, lower saturation limit (signed, fits POS_W)
POS_MAX, 32767, upper saturation limit
DB_CYCLES, 50000, clocks an input must stay stable before the debounced key level changes (1 ms at 50 MHz)
LONG_CYCLES, 50000000, clocks the debounced key must stay high to count as a long press
CLR_ON_LONG, 1, when 1 a long press clears the position to 0

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enc_a_i  in  1  raw encoder phase A (asynchronous)
enc_b_i  in  1  raw encoder phase B (asynchronous)
key_i  in  1  raw key, 1 = pressed (asynchronous, bouncy)
err_clr_i  in  1  clears err_o
step_o  out  1  one-cycle pulse per completed detent
dir_o  out  1  direction of last step, 0 = CW (A leads), 1 = CCW (B leads)
pos_o  out  POS_W  signed position
key_level_o  out  1  debounced key level
key_press_o  out  1  one-cycle pulse on debounced rising edge
key_long_o  out  1  one-cycle pulse when long-press threshold is reached
err_o  out  1  sticky illegal-transition flag

Behaviour:
- Reset: all outputs 0, pos_o = 0, and all synchronisers, counters and accumulator cleared. A prev_valid flag is cleared.
- Synchronisation: 2-flop synchroniser on each of A, B and key.
- Decode priming: the first synced A/B sample after reset only loads prev_ab (sets prev_valid), so a resting state of 11 does not raise an error.
- Quadrature decode:
  - Signed quarter accumulator qacc, range -4..+4.
  - CW sequence (ab) 00->10->11->01->00 adds +1 per transition; CCW sequence 00->01->11->10->00 adds -1.
  - No change: hold.
  - Both bits change: set err_o, clear qacc, no step.
- Step generation:
  - On entering ab = 00 with qacc = +4, pulse step_o with dir_o = 0.
  - With qacc = -4, pulse step_o with dir_o = 1.
  - With any other qacc value, no step.
  - qacc always clears on entering 00.
  - A partial rotation that reverses (+1, -1) produces no step.
- Latency: step_o is high in the 3rd cycle after the first clk edge that samples the final B-fall (CW) or A-fall (CCW): 2 sync stages plus 1 decode register.
- Position update:
  - pos_o updates on the same edge step_o rises: +1 for CW, -1 for CCW.
  - Saturates at POS_MAX/POS_MIN; step_o still pulses at a limit.
- Key debounce:
  - Counter resets whenever the synced key equals key_level_o.
  - Otherwise it increments; on reaching DB_CYCLES-1, key_level_o toggles and the counter clears.
  - A bounce shorter than DB_CYCLES never toggles the level.
- Key events:
  - key_press_o pulses in the cycle key_level_o rises.
  - A hold counter runs while key_level_o = 1.
  - key_long_o pulses once when the hold counter reaches LONG_CYCLES-1; it does not repeat until release and re-press.
- Long-press clear: if CLR_ON_LONG = 1, pos_o <= 0 on the key_long_o cycle. A clear takes priority over a simultaneous step; step_o still pulses.
- Error flag: err_o is sticky until err_clr_i; set takes priority over a same-cycle clear.
- Reset mid-rotation: state is discarded and the partial detent is lost; decoding re-primes on the next sample.

Decomposition:
- Package rot_enc_pkg holds:
  - the dir_e enum (DIR_CW = 0, DIR_CCW = 1);
  - the quarter-step lookup function qstep(prev_ab, cur_ab) returning -1/0/+1 plus an illegal flag;
  - localparam QACC_FULL = 4.
- Sub-module key_debounce (parameter DB_CYCLES; ports clk, rst, d_i, level_o, rise_o) holds the synchroniser and debounce counter.
- Quadrature decode, position counter and long-press logic stay in rot_enc_ctrl.

Test Plan:
- Params DB_CYCLES = 8, LONG_CYCLES = 64, POS_W = 8, POS_MIN = -4, POS_MAX = 3, clk period 10 ns. One CW cycle, 50 ns per quarter -> single step_o pulse, dir_o = 0, pos_o 0->1, step_o high in the 3rd cycle after B-fall is sampled.
- Three CCW cycles from pos 0 -> three pulses, dir_o = 1, pos_o = -3. Two more -> pos_o = -4 (saturated) and step_o still pulses twice.
- Key bounce of 30 x (20 ns low / 30 ns high) then held 1 for 100 cycles -> exactly one key_press_o; key_long_o once at hold count 63; pos_o cleared to 0; no repeat while still held.
- Partial rotation 00->10->00 -> no step_o, pos_o unchanged, err_o stays 0.
- A and B toggled on the same clock edge (00->11) -> err_o = 1 and no step. err_clr_i pulse -> err_o = 0. Clear issued in the same cycle as a new illegal transition -> err_o stays 1.
- Assert rst for 1 cycle after two quarter-steps of a CW cycle, encoder resting at 11 -> all outputs 0, err_o stays 0 after re-prime, completing the cycle gives no step.
